instr_fetch_unit: RTL and testbench

- Upstream neighbour of the multicycle controller.
- Fetches one 32-bit MIPS instruction as four byte reads from the 8-bit-wide memory, using a req/ack handshake.
- Assembles the bytes in a shadow buffer and commits them atomically to the instruction register.
- Presents decoded fields (op, funct, rs, rt, rd, imm) with a valid/consume handshake to the controller and datapath.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/ifu_byte_assembler.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the instruction fetch path: FSM states, MIPS field positions, bytes per word.
// Pure declarations; no latency or flow control of its own.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } ifu_state_t;

    localparam int INSTR_BYTES = 4;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_W     = 16;

endpackage

// File: rtl/ifu_byte_assembler.sv
// Collects little-endian bytes into a shadow word and commits it to the instruction register on the last byte.
// One byte per i_wr edge; the caller holds i_wr low (and the byte stays pending) while memory has not acked.
module ifu_byte_assembler #(
    parameter int INSTR_BYTES = 4,
    parameter int CW          = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic [7:0]               i_rdata,
    output logic [CW-1:0]            o_byte_cnt,
    output logic                     o_last,
    output logic [8*INSTR_BYTES-1:0] o_instr
);

    localparam int SW = 8 * INSTR_BYTES;

    logic [CW-1:0] r_byte_cnt;
    logic [SW-1:0] r_shadow;
    logic [SW-1:0] r_instr;
    logic          w_last;

    assign w_last = (r_byte_cnt == CW'(INSTR_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_byte_cnt <= '0;
            r_shadow   <= '0;
            r_instr    <= '0;
        end else if (i_clr) begin
            // Old shadow bytes are left in place; every lane is rewritten before the next commit.
            r_byte_cnt <= '0;
        end else if (i_wr) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (r_byte_cnt == CW'(i)) begin
                    r_shadow[8*i +: 8] <= i_rdata;
                end
            end
            if (w_last) begin
                r_instr    <= {i_rdata, r_shadow[SW-9:0]};
                r_byte_cnt <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    assign o_byte_cnt = r_byte_cnt;
    assign o_last     = w_last;
    assign o_instr    = r_instr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches a 32-bit instruction as four byte reads over req/ack and presents it with valid/consume.
// 5 cycles start->valid with zero-wait memory; mem_addr holds until ack; VALID holds until consume or flush.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  flush,
    input  logic                  consume,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           instr,
    output logic [5:0]            op,
    output logic [5:0]            funct,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [15:0]           imm,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  busy
);

    import mips_pkg::*;

    localparam int CW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    ifu_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_pc_next;

    logic                  w_launch;
    logic                  w_wr;
    logic                  w_clr;
    logic                  w_last;
    logic [CW-1:0]         w_byte_cnt;
    logic [31:0]           w_instr;

    // A new fetch may only begin from IDLE, or from VALID in the same cycle the instruction is taken.
    assign w_launch = !flush && start &&
                      ((r_state == S_IDLE) || ((r_state == S_VALID) && consume));
    assign w_wr     = (r_state == S_FETCH) && mem_ack && !flush;
    assign w_clr    = flush || w_launch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_pc_next <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= pc_in;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack && w_last) begin
                        r_pc_next <= r_base + ADDR_WIDTH'(INSTR_BYTES);
                        r_state   <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (consume) begin
                        if (start) begin
                            r_base  <= pc_in;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    ifu_byte_assembler #(
        .INSTR_BYTES (INSTR_BYTES),
        .CW          (CW)
    ) u_asm (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clr      (w_clr),
        .i_wr       (w_wr),
        .i_rdata    (mem_rdata),
        .o_byte_cnt (w_byte_cnt),
        .o_last     (w_last),
        .o_instr    (w_instr)
    );

    assign busy        = (r_state == S_FETCH);
    assign mem_req     = busy;
    assign instr_valid = (r_state == S_VALID);
    assign mem_addr    = busy ? (r_base + ADDR_WIDTH'(w_byte_cnt)) : '0;
    assign pc_next     = r_pc_next;

    assign instr = w_instr;
    assign op    = w_instr[OP_MSB:OP_LSB];
    assign rs    = w_instr[RS_MSB:RS_LSB];
    assign rt    = w_instr[RT_MSB:RT_LSB];
    assign rd    = w_instr[RD_MSB:RD_LSB];
    assign funct = w_instr[FUNCT_MSB:FUNCT_LSB];
    assign imm   = w_instr[IMM_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic against a byte-memory reference model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  pc_in;
    logic        flush;
    logic        consume;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        instr_valid;
    logic [7:0]  pc_next;
    logic        busy;

    instr_fetch_unit #(.ADDR_WIDTH(8), .INSTR_BYTES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_in       (pc_in),
        .flush       (flush),
        .consume     (consume),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .instr_valid (instr_valid),
        .pc_next     (pc_next),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the unit is doing, measured in bytes delivered by memory.
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_VALID = 2;

    logic [7:0]  mem [256];
    int          m_phase;
    logic [7:0]  m_base;
    int          m_got;
    logic [31:0] m_instr;
    logic [7:0]  m_pcn;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] b);
        logic [7:0] a0, a1, a2, a3;
        a0 = b;
        a1 = b + 8'd1;
        a2 = b + 8'd2;
        a3 = b + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a0]};
    endfunction

    task automatic check_all();
        logic [7:0] exp_addr;
        exp_addr = m_base + 8'(m_got);
        chk("mem_req", 32'(mem_req), 32'(m_phase == M_FETCH));
        chk("busy", 32'(busy), 32'(m_phase == M_FETCH));
        chk("instr_valid", 32'(instr_valid), 32'(m_phase == M_VALID));
        if (m_phase == M_FETCH) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("instr", instr, m_instr);
        chk("pc_next", 32'(pc_next), 32'(m_pcn));
        chk("op", 32'(op), 32'(m_instr >> 26));
        chk("funct", 32'(funct), 32'(m_instr % 64));
        chk("rs", 32'(rs), 32'((m_instr >> 21) % 32));
        chk("rt", 32'(rt), 32'((m_instr >> 16) % 32));
        chk("rd", 32'(rd), 32'((m_instr >> 11) % 32));
        chk("imm", 32'(imm), 32'(m_instr % 65536));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare at the falling edge.
    task automatic cycle(input bit rst_n, input bit st, input logic [7:0] pc,
                         input bit fl, input bit cons, input bit ack);
        logic [7:0] a;
        a         = m_base + 8'(m_got);
        reset     = rst_n;
        start     = st;
        pc_in     = pc;
        flush     = fl;
        consume   = cons;
        mem_ack   = ack;
        mem_rdata = (m_phase == M_FETCH) ? mem[a] : 8'($urandom);
        @(posedge clk);
        if (!rst_n) begin
            m_phase = M_IDLE; m_base = '0; m_got = 0; m_instr = '0; m_pcn = '0;
        end else if (fl) begin
            m_phase = M_IDLE; m_got = 0;
        end else if (m_phase == M_IDLE) begin
            if (st) begin m_base = pc; m_got = 0; m_phase = M_FETCH; end
        end else if (m_phase == M_FETCH) begin
            if (ack) m_got++;
            if (m_got == 4) begin
                m_instr = word_at(m_base);
                m_pcn   = m_base + 8'd4;
                m_got   = 0;
                m_phase = M_VALID;
            end
        end else if (cons) begin
            if (st) begin m_base = pc; m_got = 0; m_phase = M_FETCH; end
            else m_phase = M_IDLE;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        logic [31:0] saved;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h8C; mem[8'h11] = 8'h00; mem[8'h12] = 8'h22; mem[8'h13] = 8'hAC;
        m_phase = M_IDLE; m_base = '0; m_got = 0; m_instr = '0; m_pcn = '0;

        // Reset, with other inputs active to show reset dominates.
        cycle(0, 1, 8'h55, 0, 1, 1);
        cycle(0, 0, 8'h00, 0, 0, 0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_next", 32'(pc_next), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);

        // Zero-wait fetch at 0x10; ack in IDLE is ignored.
        cycle(1, 1, 8'h10, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            chk("zw_addr", 32'(mem_addr), 32'h10 + 32'(k));
            cycle(1, 0, 8'h00, 0, 0, 1);
        end
        chk("zw_instr", instr, 32'hAC22008C);
        chk("zw_op", 32'(op), 32'h2B);
        chk("zw_rt", 32'(rt), 32'h02);
        chk("zw_imm", 32'(imm), 32'h008C);
        chk("zw_pc_next", 32'(pc_next), 32'h14);
        chk("zw_valid", 32'(instr_valid), 32'd1);

        // Back-to-back fetch from VALID, then two-cycle wait states per byte.
        cycle(1, 1, 8'h14, 0, 1, 0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_addr", 32'(mem_addr), 32'h14);
        chk("b2b_op_hold", 32'(op), 32'h2B);
        n = 1;
        while (!instr_valid && n < 30) begin
            cycle(1, 0, 8'h00, 0, 0, (n % 3) == 0);
            n++;
        end
        chk("ws_latency", 32'(n), 32'd13);
        chk("ws_instr", instr, word_at(8'h14));
        cycle(1, 0, 8'h00, 0, 1, 0);

        // Address wrap-around.
        cycle(1, 1, 8'hFE, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 8'h00, 0, 0, 1);
        chk("wrap_pc_next", 32'(pc_next), 32'h02);
        chk("wrap_instr", instr, {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]});
        saved = instr;
        cycle(1, 0, 8'h00, 0, 1, 0);

        // Flush after two bytes, with an ack on the flush edge and a late ack afterwards.
        cycle(1, 1, 8'h20, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 1);
        cycle(1, 0, 8'h00, 0, 0, 1);
        cycle(1, 1, 8'h40, 1, 1, 1);
        chk("fl_req", 32'(mem_req), 32'd0);
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_instr_kept", instr, saved);
        cycle(1, 0, 8'h00, 0, 0, 1);
        chk("fl_late_ack", 32'(busy), 32'd0);
        cycle(1, 1, 8'h20, 0, 0, 0);
        chk("fl_restart_addr", 32'(mem_addr), 32'h20);
        for (int k = 0; k < 4; k++) cycle(1, 0, 8'h00, 0, 0, 1);
        chk("fl_refetch", instr, word_at(8'h20));

        // Reset in the middle of a fetch.
        cycle(1, 0, 8'h00, 0, 1, 0);
        cycle(1, 1, 8'h30, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 1);
        cycle(0, 1, 8'h31, 0, 0, 1);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_pc_next", 32'(pc_next), 32'd0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 97) != 0, ($urandom % 2) == 0, 8'($urandom),
                  ($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
